// File: rtl/dplca_txop_if.sv
// Event inputs and table outputs exchanged between the PLCA observer and the DPLCA state diagram.
interface dplca_txop_if #(
  parameter int unsigned CNT_W = 8
);
  logic              beacon_rx;
  logic [7:0]        beacon_node_count;
  logic              txop_end;
  logic [7:0]        txop_cur_id;
  logic              txop_busy;
  logic [255:0]      txop_claim_table;
  logic              dplca_txop_table_upd;
  logic [7:0]        dplca_txop_id;
  logic [7:0]        dplca_txop_node_count;
  logic              dplca_new_age;
  logic [CNT_W-1:0]  age_cnt;

  // Driver side: produces PLCA events, consumes the claim table.
  modport master (
    output beacon_rx, beacon_node_count, txop_end, txop_cur_id, txop_busy,
    input  txop_claim_table, dplca_txop_table_upd, dplca_txop_id,
           dplca_txop_node_count, dplca_new_age, age_cnt
  );

  // Table side: consumes PLCA events, produces the claim table.
  modport slave (
    input  beacon_rx, beacon_node_count, txop_end, txop_cur_id, txop_busy,
    output txop_claim_table, dplca_txop_table_upd, dplca_txop_id,
           dplca_txop_node_count, dplca_new_age, age_cnt
  );
endinterface

// File: rtl/dplca_txop_table.sv
// DPLCA TXOP claim table: tracks busy TXOPs per PLCA cycle with two-window aging.
module dplca_txop_table #(
  parameter int unsigned AGE_CYCLES = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         plca_reset_i,
  input  logic         dplca_aging_i,
  dplca_txop_if.slave  bus
);
  localparam int unsigned N_TXOP = 256;
  localparam int unsigned ID_W   = 8;

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_e;

  state_e              state_q, state_d;
  logic [N_TXOP-1:0]   cur_tbl_q, cur_tbl_d;
  logic [N_TXOP-1:0]   prev_tbl_q, prev_tbl_d;
  logic [N_TXOP-1:0]   claim_q, claim_d;
  logic                upd_q, upd_d;
  logic [ID_W-1:0]     txop_id_q, txop_id_d;
  logic [ID_W-1:0]     node_cnt_q, node_cnt_d;
  logic                new_age_q, new_age_d;
  logic [CNT_W-1:0]    age_cnt_q, age_cnt_d;
  logic [CNT_W-1:0]    age_inc;
  logic                txop_end_prev_q, beacon_prev_q;
  logic                txop_rise, beacon_rise;

  // Wide event pulses count once, on their rising edge.
  assign txop_rise   = bus.txop_end  & ~txop_end_prev_q;
  assign beacon_rise = bus.beacon_rx & ~beacon_prev_q;
  assign age_inc     = age_cnt_q + CNT_W'(1);

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cur_tbl_q       <= '0;
      prev_tbl_q      <= '0;
      claim_q         <= '0;
      upd_q           <= 1'b0;
      txop_id_q       <= '0;
      node_cnt_q      <= '0;
      new_age_q       <= 1'b0;
      age_cnt_q       <= '0;
      txop_end_prev_q <= 1'b0;
      beacon_prev_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_tbl_q       <= cur_tbl_d;
      prev_tbl_q      <= prev_tbl_d;
      claim_q         <= claim_d;
      upd_q           <= upd_d;
      txop_id_q       <= txop_id_d;
      node_cnt_q      <= node_cnt_d;
      new_age_q       <= new_age_d;
      age_cnt_q       <= age_cnt_d;
      txop_end_prev_q <= bus.txop_end;
      beacon_prev_q   <= bus.beacon_rx;
    end
  end

  // Next-state: sync to the first BEACON, then record TXOPs and rotate windows.
  always_comb begin
    state_d    = state_q;
    cur_tbl_d  = cur_tbl_q;
    prev_tbl_d = prev_tbl_q;
    upd_d      = 1'b0;
    txop_id_d  = txop_id_q;
    node_cnt_d = node_cnt_q;
    new_age_d  = new_age_q;
    age_cnt_d  = age_cnt_q;

    if (plca_reset_i) begin
      state_d    = IDLE;
      cur_tbl_d  = '0;
      prev_tbl_d = '0;
      txop_id_d  = '0;
      node_cnt_d = '0;
      new_age_d  = 1'b0;
      age_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cur_tbl_d  = '0;
          prev_tbl_d = '0;
          new_age_d  = 1'b0;
          age_cnt_d  = '0;
          if (dplca_aging_i) state_d = SYNC;
        end
        SYNC: begin
          if (!dplca_aging_i) begin
            state_d    = IDLE;
            cur_tbl_d  = '0;
            prev_tbl_d = '0;
            new_age_d  = 1'b0;
            age_cnt_d  = '0;
          end else if (beacon_rise) begin
            node_cnt_d = bus.beacon_node_count;
            age_cnt_d  = '0;
            state_d    = RUN;
          end
        end
        RUN: begin
          if (!dplca_aging_i) begin
            state_d    = IDLE;
            cur_tbl_d  = '0;
            prev_tbl_d = '0;
            new_age_d  = 1'b0;
            age_cnt_d  = '0;
          end else begin
            // The TXOP is written first so a coincident rotation carries it into prev.
            if (txop_rise) begin
              cur_tbl_d[bus.txop_cur_id] = cur_tbl_q[bus.txop_cur_id] | bus.txop_busy;
              txop_id_d = bus.txop_cur_id;
              upd_d     = 1'b1;
            end
            if (beacon_rise) begin
              node_cnt_d = bus.beacon_node_count;
              if (age_inc == CNT_W'(AGE_CYCLES)) begin
                prev_tbl_d = cur_tbl_d;
                cur_tbl_d  = '0;
                age_cnt_d  = '0;
                new_age_d  = 1'b1;
              end else begin
                age_cnt_d  = age_inc;
                new_age_d  = 1'b0;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    claim_d = cur_tbl_d | prev_tbl_d;
  end

  assign bus.txop_claim_table      = claim_q;
  assign bus.dplca_txop_table_upd  = upd_q;
  assign bus.dplca_txop_id         = txop_id_q;
  assign bus.dplca_txop_node_count = node_cnt_q;
  assign bus.dplca_new_age         = new_age_q;
  assign bus.age_cnt               = age_cnt_q;
endmodule

// File: tb/tb_dplca_txop_table.sv
// Randomized and directed checks of the TXOP claim table against a window-number model.
module tb_dplca_txop_table;
  localparam int unsigned AGE   = 4;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic plca_reset = 1'b0;
  logic aging = 1'b0;

  dplca_txop_if #(.CNT_W(CNT_W)) bus ();

  dplca_txop_table #(.AGE_CYCLES(AGE), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .plca_reset_i (plca_reset),
    .dplca_aging_i(aging),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a TXOP is claimed while its last busy report lies in the current or previous window.
  localparam int M_IDLE = 0, M_SYNC = 1, M_RUN = 2;
  int         m_state;
  int         m_cycles;
  int         last_win [256];
  logic [7:0] m_id, m_nc;
  logic       m_upd, m_prev_t, m_prev_b;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_clear_tables();
    foreach (last_win[i]) last_win[i] = -10;
    m_cycles = 0;
  endtask

  task automatic m_reset();
    m_state = M_IDLE;
    m_clear_tables();
    m_id = '0; m_nc = '0; m_upd = 1'b0;
    m_prev_t = 1'b0; m_prev_b = 1'b0;
  endtask

  function automatic logic [255:0] m_claim();
    logic [255:0] c = '0;
    int win = m_cycles / int'(AGE);
    if (m_state == M_RUN)
      for (int i = 0; i < 256; i++) c[i] = (win - last_win[i] <= 1);
    return c;
  endfunction

  function automatic logic m_new_age();
    return (m_state == M_RUN) && (m_cycles > 0) && (m_cycles % int'(AGE) == 0);
  endfunction

  function automatic logic [CNT_W-1:0] m_age();
    return (m_state == M_RUN) ? CNT_W'(m_cycles % int'(AGE)) : '0;
  endfunction

  task automatic m_update(input logic ag, input logic pr, input logic b, input logic [7:0] nc,
                          input logic t, input logic [7:0] id, input logic bz);
    logic rt, rb;
    rt = t & ~m_prev_t;
    rb = b & ~m_prev_b;
    m_prev_t = t;
    m_prev_b = b;
    m_upd = 1'b0;
    if (pr) begin
      m_state = M_IDLE; m_clear_tables(); m_id = '0; m_nc = '0;
    end else if (m_state == M_IDLE) begin
      if (ag) m_state = M_SYNC;
    end else if (!ag) begin
      m_state = M_IDLE; m_clear_tables();
    end else if (m_state == M_SYNC) begin
      if (rb) begin m_nc = nc; m_cycles = 0; m_state = M_RUN; end
    end else begin
      if (rt) begin
        if (bz) last_win[id] = m_cycles / int'(AGE);
        m_id = id;
        m_upd = 1'b1;
      end
      if (rb) begin m_nc = nc; m_cycles++; end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/table"}, bus.txop_claim_table, m_claim());
    chk({tag, "/upd"}, 256'(bus.dplca_txop_table_upd), 256'(m_upd));
    chk({tag, "/id"}, 256'(bus.dplca_txop_id), 256'(m_id));
    chk({tag, "/nc"}, 256'(bus.dplca_txop_node_count), 256'(m_nc));
    chk({tag, "/new_age"}, 256'(bus.dplca_new_age), 256'(m_new_age()));
    chk({tag, "/age_cnt"}, 256'(bus.age_cnt), 256'(m_age()));
  endtask

  // One clock: drive inputs, let the edge pass, update the model and compare.
  task automatic step(input logic ag, input logic pr, input logic b, input logic [7:0] nc,
                      input logic t, input logic [7:0] id, input logic bz, input string tag);
    aging = ag; plca_reset = pr;
    bus.beacon_rx = b; bus.beacon_node_count = nc;
    bus.txop_end = t; bus.txop_cur_id = id; bus.txop_busy = bz;
    @(posedge clk);
    #1;
    m_update(ag, pr, b, nc, t, id, bz);
    check_all(tag);
  endtask

  task automatic idle(input logic ag);
    step(ag, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, "idle");
  endtask

  task automatic beacon(input logic [7:0] nc);
    step(1'b1, 1'b0, 1'b1, nc, 1'b0, 8'd0, 1'b0, "beacon");
  endtask

  task automatic txop(input logic [7:0] id, input logic bz);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, id, bz, "txop");
  endtask

  initial begin
    logic cur_ag;
    bus.beacon_rx = 1'b0; bus.beacon_node_count = '0;
    bus.txop_end = 1'b0; bus.txop_cur_id = '0; bus.txop_busy = 1'b0;
    m_reset();
    #1 rst_n = 1'b0;
    #1 check_all("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Enable, SYNC filter, first beacon.
    idle(1'b1);
    txop(8'd2, 1'b1);
    chk("sync_no_upd", 256'(bus.dplca_txop_table_upd), 256'(0));
    chk("sync_bit2", 256'(bus.txop_claim_table[2]), 256'(0));
    idle(1'b1);
    beacon(8'd8);
    chk("sync_nc", 256'(bus.dplca_txop_node_count), 256'(8));

    // Claim and update.
    txop(8'd3, 1'b1);
    chk("claim_upd", 256'(bus.dplca_txop_table_upd), 256'(1));
    chk("claim_id", 256'(bus.dplca_txop_id), 256'(3));
    chk("claim_bit3", 256'(bus.txop_claim_table[3]), 256'(1));
    idle(1'b1);
    chk("upd_single", 256'(bus.dplca_txop_table_upd), 256'(0));
    txop(8'd4, 1'b0);
    chk("idle_bit4", 256'(bus.txop_claim_table[4]), 256'(0));
    idle(1'b1);

    // Two-window aging of id 5.
    txop(8'd5, 1'b1);
    idle(1'b1);
    for (int k = 1; k <= 8; k++) begin
      beacon(8'd8);
      idle(1'b1);
      if (k == 4) begin
        chk("age_new_age", 256'(bus.dplca_new_age), 256'(1));
        chk("age_bit5_kept", 256'(bus.txop_claim_table[5]), 256'(1));
      end
      if (k == 5) chk("age_new_age_drop", 256'(bus.dplca_new_age), 256'(0));
      if (k == 8) chk("age_bit5_released", 256'(bus.txop_claim_table[5]), 256'(0));
    end

    // TXOP coincident with the rotating beacon.
    for (int k = 9; k <= 11; k++) begin beacon(8'd8); idle(1'b1); end
    step(1'b1, 1'b0, 1'b1, 8'd8, 1'b1, 8'd7, 1'b1, "coincide");
    chk("coincide_upd", 256'(bus.dplca_txop_table_upd), 256'(1));
    chk("coincide_new_age", 256'(bus.dplca_new_age), 256'(1));
    chk("coincide_bit7", 256'(bus.txop_claim_table[7]), 256'(1));
    idle(1'b1);

    // Aging disable clears everything and drops the pending update.
    txop(8'd0, 1'b1); idle(1'b1);
    txop(8'd9, 1'b1); idle(1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd11, 1'b1, "disable");
    chk("disable_upd", 256'(bus.dplca_txop_table_upd), 256'(0));
    chk("disable_table", bus.txop_claim_table, 256'(0));
    idle(1'b1);
    txop(8'd2, 1'b1);
    chk("resync_no_upd", 256'(bus.dplca_txop_table_upd), 256'(0));
    idle(1'b1);
    beacon(8'd5);
    txop(8'd20, 1'b1);
    idle(1'b1);

    // Asynchronous reset mid-RUN, then re-enable.
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all("arst");
    chk("arst_table", bus.txop_claim_table, 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1'b1);
    beacon(8'd8);
    chk("reen_nc", 256'(bus.dplca_txop_node_count), 256'(8));
    chk("reen_age", 256'(bus.age_cnt), 256'(0));

    // Random traffic, including held pulses, disables and PLCA resets.
    cur_ag = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] rid;
      if (cur_ag && $urandom_range(0, 199) == 0) cur_ag = 1'b0;
      else if (!cur_ag && $urandom_range(0, 3) == 0) cur_ag = 1'b1;
      rid = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      if ($urandom_range(0, 3) == 0) rid = 8'd255;
      step(cur_ag, ($urandom_range(0, 499) == 0), ($urandom_range(0, 9) == 0),
           8'($urandom), ($urandom_range(0, 2) == 0), rid, ($urandom_range(0, 2) != 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
